// File: rtl/sram_controller.sv
// MEM-stage bridge to a 16-bit external SRAM: each 32-bit load/store becomes
// two fixed-length half-word accesses while `ready` freezes the pipeline.
module sram_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 3,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_COUNT = 4'(ACCESS_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [3:0]         counter;
  logic               op_write;
  logic [SRAM_AW-2:0] word_index;
  logic [31:0]        wdata;
  logic [15:0]        lo_buf;
  logic [31:0]        offset;
  logic               request;
  logic               last_cycle;
  logic               unused_offset_bits;

  // Offset wraps modulo 2^32 for addresses below the origin; only the bits
  // that fit the SRAM half-word address are kept.
  assign offset             = address - 32'(BASE_ADDR);
  assign request            = rd_en | wr_en;
  assign last_cycle         = (counter == LAST_COUNT);
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter    <= '0;
      op_write   <= 1'b0;
      word_index <= '0;
      wdata      <= '0;
      lo_buf     <= '0;
      read_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            op_write   <= wr_en;
            word_index <= offset[SRAM_AW:2];
            wdata      <= write_data;
            counter    <= '0;
          end
        end
        LO: begin
          if (last_cycle) begin
            counter <= '0;
            if (!op_write) lo_buf <= sram_dq_in;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        HI: begin
          if (last_cycle) begin
            counter <= '0;
            if (!op_write) read_data <= {sram_dq_in, lo_buf};
          end else begin
            counter <= counter + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM pins are idle outside LO/HI; ready is combinational in IDLE so a
  // new request freezes the pipeline in the cycle it first appears.
  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: begin
        ready = !request;
        if (request) state_next = LO;
      end
      LO: begin
        sram_addr = {word_index, 1'b0};
        if (op_write) begin
          sram_dq_out = wdata[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last_cycle) state_next = HI;
      end
      HI: begin
        sram_addr = {word_index, 1'b1};
        if (op_write) begin
          sram_dq_out = wdata[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last_cycle) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: an SRAM model on the pins plus a
// word-level reference memory that predicts pins, latency and load data.
module tb_sram_controller;

  localparam int BASE     = 1024;
  localparam int AC       = 3;
  localparam int AW       = 18;
  localparam int DONE_CYC = 2 * AC + 1;
  localparam int MEM_SIZE = 1 << AW;

  logic          clk;
  logic          rst;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_we_n;

  logic [15:0] sram_mem [0:MEM_SIZE-1];
  logic [15:0] ref_mem  [0:MEM_SIZE-1];

  int          checkCount = 0;
  int          failCount  = 0;
  logic [31:0] expReadData;

  sram_controller #(
    .BASE_ADDR(BASE),
    .ACCESS_CYCLES(AC),
    .SRAM_AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] initWord(input int unsigned i);
    return 16'((i * 32'd40503) ^ 32'h5A3C);
  endfunction

  // External SRAM: asynchronous read, write committed on a clock edge while strobed.
  assign sram_dq_in = sram_mem[sram_addr];

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) sram_mem[i] = initWord(i);
    forever begin
      @(posedge clk);
      if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end
  end

  function automatic logic [AW-1:0] halfAddr(input logic [31:0] addr, input int unsigned half);
    longint unsigned idx;
    idx = 64'((addr - 32'(BASE)) >> 2);
    return AW'((idx * 64'd2 + 64'(half)) % (64'd1 << AW));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic checkPins(input string ctx, input logic expReady, input logic [AW-1:0] expAddr,
                           input logic expOe, input logic expWeN, input logic checkDq,
                           input logic [15:0] expDq);
    checkOutput({ctx, ".ready"}, 32'(ready), 32'(expReady));
    checkOutput({ctx, ".sram_addr"}, 32'(sram_addr), 32'(expAddr));
    checkOutput({ctx, ".dq_oe"}, 32'(sram_dq_oe), 32'(expOe));
    checkOutput({ctx, ".we_n"}, 32'(sram_we_n), 32'(expWeN));
    if (checkDq) checkOutput({ctx, ".dq_out"}, 32'(sram_dq_out), 32'(expDq));
    checkOutput({ctx, ".read_data"}, read_data, expReadData);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the IDLE
  // cycle after DONE. Inputs are scrambled mid-transaction to prove they are ignored.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data);
    logic          isWrite;
    logic [AW-1:0] aLo;
    logic [AW-1:0] aHi;
    isWrite = wr;
    aLo = halfAddr(addr, 0);
    aHi = halfAddr(addr, 1);
    rd_en = rd;
    wr_en = wr;
    address = addr;
    write_data = data;
    for (int k = 0; k <= DONE_CYC; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkPins("req", 1'b0, '0, 1'b0, 1'b1, 1'b0, 16'h0);
      end else if (k <= AC) begin
        checkPins("lo", 1'b0, aLo, isWrite, !isWrite, isWrite, data[15:0]);
      end else if (k <= 2 * AC) begin
        checkPins("hi", 1'b0, aHi, isWrite, !isWrite, isWrite, data[31:16]);
      end else begin
        if (isWrite) begin
          ref_mem[aLo] = data[15:0];
          ref_mem[aHi] = data[31:16];
          checkOutput("mem_lo", 32'(sram_mem[aLo]), 32'(ref_mem[aLo]));
          checkOutput("mem_hi", 32'(sram_mem[aHi]), 32'(ref_mem[aHi]));
        end else begin
          expReadData = {ref_mem[aHi], ref_mem[aLo]};
        end
        checkPins("done", 1'b1, '0, 1'b0, 1'b1, 1'b1, 16'h0);
      end
      nextCycle();
      if (k < 2 * AC) begin
        rd_en = 1'($urandom);
        wr_en = 1'($urandom);
        address = $urandom;
        write_data = $urandom;
      end else if (k == 2 * AC) begin
        rd_en = 1'b0;
        wr_en = 1'b0;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkPins("idle", 1'b1, '0, 1'b0, 1'b1, 1'b1, 16'h0);
      nextCycle();
    end
  endtask

  // Store aborted by reset in its first HI cycle: only the low half lands.
  task automatic resetAbort(input logic [31:0] addr, input logic [31:0] data);
    logic [AW-1:0] aLo;
    logic [AW-1:0] aHi;
    aLo = halfAddr(addr, 0);
    aHi = halfAddr(addr, 1);
    rd_en = 1'b0;
    wr_en = 1'b1;
    address = addr;
    write_data = data;
    nextCycle();
    wr_en = 1'b0;
    for (int i = 0; i < AC; i++) nextCycle();
    #2 rst = 1'b1;
    expReadData = '0;
    ref_mem[aLo] = data[15:0];
    @(negedge clk);
    checkPins("rst_abort", 1'b1, '0, 1'b0, 1'b1, 1'b1, 16'h0);
    #1 rst = 1'b0;
    nextCycle();
    checkOutput("rst_abort.mem_lo", 32'(sram_mem[aLo]), 32'(ref_mem[aLo]));
    checkOutput("rst_abort.mem_hi", 32'(sram_mem[aHi]), 32'(ref_mem[aHi]));
  endtask

  initial begin
    logic [31:0] addr;
    int unsigned sel;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = initWord(i);
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = '0;
    write_data = '0;
    expReadData = '0;

    @(negedge clk);
    checkPins("reset", 1'b1, '0, 1'b0, 1'b1, 1'b1, 16'h0);
    #2 rst = 1'b0;
    nextCycle();
    idleCycles(10);

    applyStimulus(1'b0, 1'b1, 32'd1028, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
    resetAbort(32'd1028, 32'hA5A55A5A);
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'd1032, 32'hCAFEBABE);
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1029, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'd0, 32'h0BADF00D);
    applyStimulus(1'b1, 1'b0, 32'd3, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd1034, 32'h0);

    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) addr = 32'($urandom_range(0, 1023));
      else addr = 32'(BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3));
      applyStimulus(sel != 1, sel != 0, addr, $urandom);
      idleCycles($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
Sequences the external 16-bit SRAM for the MEM stage of the ARM-style pipeline. Each 32-bit load or store is split into two half-word SRAM accesses of fixed length. `ready` is deasserted for the whole transaction so the top level can freeze every pipeline register, including the IF/ID and ID/EX registers, until the access retires. The block sits between the MEM stage and the SRAM pins and replaces the on-chip data memory.

Parameters:
BASE_ADDR, 1024, byte address of data-memory origin; subtracted from `address` before translation
ACCESS_CYCLES, 3, clock cycles each half-word access is held on the SRAM pins (legal 1..15)
SRAM_AW, 18, SRAM half-word address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
rd_en  input  1  MEM stage load request (level)
wr_en  input  1  MEM stage store request (level)
address  input  32  byte address from EXE result
write_data  input  32  store data (val_Rm path)
read_data  output  32  load data, valid from DONE onward
ready  output  1  1 = no transaction pending; 0 = freeze pipeline
sram_addr  output  SRAM_AW  SRAM half-word address
sram_dq_out  output  16  data driven toward SRAM
sram_dq_oe  output  1  1 = drive sram_dq_out onto the SRAM bus
sram_dq_in  input  16  data returned from SRAM bus
sram_we_n  output  1  SRAM write strobe, active-low

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, latched op/address/data=0. Reset mid-transaction aborts immediately to these values; no partial write completes.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - If rd_en|wr_en, latch op (write if wr_en, else read), the word index ((address - BASE_ADDR) >> 2) and write_data, clear counter, go to LO.
  - Otherwise stay.
  - ready = !(rd_en|wr_en), combinational, so the pipeline is frozen in the same cycle the request appears.
- LO:
  - sram_addr = {word_index, 1'b0}, truncated to SRAM_AW.
  - For writes: sram_dq_out = wdata[15:0], sram_dq_oe=1, sram_we_n=0.
  - For reads: sram_dq_oe=0, sram_we_n=1.
  - Counter increments each cycle. On the cycle where counter == ACCESS_CYCLES-1:
    - for reads, capture sram_dq_in into an internal lo buffer;
    - clear counter and go to HI.
  - ready=0.
- HI:
  - Same as LO, with sram_addr = {word_index, 1'b1} and wdata[31:16].
  - On the final cycle, for reads, read_data <= {sram_dq_in, lo_buf}. Then go to DONE.
  - ready=0.
- DONE:
  - SRAM pins idle (we_n=1, oe=0, addr=0). ready=1 for exactly one cycle; the pipeline advances on this edge.
  - Go to IDLE unconditionally.
  - A new request is sampled only in the following IDLE cycle.
- SRAM pins in IDLE and DONE: sram_addr=0, sram_dq_oe=0, sram_we_n=1 (Moore outputs decoded from state).
- Latency: request first seen at cycle 0 gives DONE at cycle 2*ACCESS_CYCLES+1. With the default this is 7 frozen cycles, and ready=1 in cycle 7.
- rd_en and wr_en both high: treated as a write.
- Request dropped or changed mid-transaction: ignored. The latched op, address and data complete unchanged.
- read_data holds its last load value through writes and idle periods. It changes only at the end of HI of a read, or on reset.
- Address rules:
  - address[1:0] is ignored (word aligned).
  - address < BASE_ADDR wraps modulo 2^32 and is then truncated; no error is signalled.
- Back-to-back requests: after DONE, IDLE sees the next request in that cycle. Each transaction therefore costs 2*ACCESS_CYCLES+2 cycles including the IDLE cycle.

Test Plan:
- Idle with rd_en=wr_en=0 for 10 cycles -> ready=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0 throughout.
- Store 0x12345678 to address 1028 -> ready=0 cycles 0-6, 1 in cycle 7:
  - cycles 1-3: sram_addr=2, dq_out=0x5678, we_n=0, oe=1;
  - cycles 4-6: sram_addr=3, dq_out=0x1234, we_n=0;
  - SRAM model holds both half-words afterward.
- Load from 1028 with the model returning 0x5678/0x1234 -> read_data=0x12345678 in cycle 7. we_n stays 1 and oe stays 0 throughout; ready low cycles 0-6.
- Assert rst in cycle 4 of a store -> outputs return to reset values immediately; SRAM address 3 is not written; next request starts cleanly from IDLE.
- rd_en=wr_en=1, address 1032, data 0xCAFEBABE -> write performed to sram_addr 4/5; read_data unchanged.
- Two back-to-back loads from 1024 then 1028 -> DONE cycles at 7 and 15, each returning the correct word. Changing address during the first transaction does not affect it.
